spi_slave_core: RTL and testbench
=================================

# spi_slave_core

SPI slave endpoint: the far side of the SPI master core, used in loopback benches and in designs where this chip is the SPI target of an external controller. All SPI pins are oversampled and synchronised into the single system clock. The core shifts one CHAR_LEN-bit character per frame in each direction. It presents the received data with a valid/ack handshake and accepts transmit data through a one-word valid/ready buffer. It supports all four CPOL/CPHA modes.

## Interface
- CHAR_LEN, 8: character length in bits, legal range 1..32.
- SYNC_STAGES, 2: synchroniser depth on sclk_in, ss_n_in and mosi_in, legal range 2..3.

Ports:
- wb_clk_in  in  1  system clock. It must be at least 4x the maximum sclk_in frequency.
- wb_rst_n_in  in  1  asynchronous active-low reset.
- cpol_in  in  1  SPI clock idle level.
- cpha_in  in  1  0 = sample on leading edge; 1 = sample on trailing edge.
- lsb_in  in  1  1 = LSB first. Only honoured with SPI_SLV_LSB_EN.
- sclk_in  in  1  SPI clock from the master, asynchronous.
- ss_n_in  in  1  slave select, active-low, asynchronous.
- mosi_in  in  1  serial data in, asynchronous.
- miso_out  out  1  serial data out.
- miso_oe_out  out  1  output enable for miso_out; equals the synchronised ~ss_n.
- tx_dat_in  in  CHAR_LEN  transmit word.
- tx_valid_in  in  1  transmit word valid.
- tx_ready_out  out  1  transmit buffer empty.
- rx_dat_out  out  CHAR_LEN  last received character.
- rx_valid_out  out  1  rx_dat_out holds unread data. Level signal; held until acknowledged.
- rx_ack_in  in  1  consumer acknowledge; clears rx_valid_out.
- rx_overrun_out  out  1  one-cycle pulse: a character completed while rx_valid_out was high.
- tx_underrun_out  out  1  one-cycle pulse: a character started with an empty tx buffer.
- busy_out  out  1  high while in SHIFT.

## Operation
- Synchronisation: sclk_in, ss_n_in and mosi_in each pass through SYNC_STAGES flops. One additional flop on sclk provides edge detection.
- Leading edge: the transition away from the cpol_in level. Trailing edge: the transition back to it.
- Sample edge: the leading edge when cpha=0, the trailing edge when cpha=1. Shift edge: the other edge.
- Mode latch: cpol_in, cpha_in and lsb_in are latched on the synchronised ss_n falling edge. Changes during a frame are ignored.
- FSM states:
  - IDLE: ss_n high. → LOAD on synchronised ss_n fall.
  - LOAD: one cycle. The tx shift register loads the tx buffer if it is full and the buffer empties. If the buffer is empty, all-zeros is loaded and tx_underrun_out pulses. The bit counter clears. → SHIFT.
  - SHIFT: each sample edge shifts the synchronised mosi into the rx shift register and increments the bit counter. Each shift edge advances the tx shift register. When cpha=1, the first leading edge does not shift. On the CHAR_LEN-th sample edge, the rx shift register is copied to rx_dat_out and rx_valid_out is set. → LOAD if ss_n is still low (back-to-back characters), else IDLE.
  - Any state: synchronised ss_n high → IDLE. A partial character is discarded: no rx_valid_out, counter cleared. A tx word already loaded is lost.
- miso_out: the tx shift register MSB, or its LSB when lsb is active. Driven 0 in IDLE.
- Transmit buffer: the write fires when tx_valid_in & tx_ready_out. A write in the same cycle as LOAD with an empty buffer does not reach that character: zeros are sent, underrun pulses, and the word is held for the next character.
- Receive, simultaneous events:
  - rx_ack_in and completion in the same cycle: rx_valid_out stays 1 with the new data and there is no overrun.
  - Completion while rx_valid_out=1 without ack: rx_dat_out is overwritten and rx_overrun_out pulses.
- Bit counter width: $clog2(CHAR_LEN+1). It wraps to 0 on completion.

## Timing
- Reset values: miso_out=0, miso_oe_out=0, tx_ready_out=1, rx_dat_out=0, rx_valid_out=0, rx_overrun_out=0, tx_underrun_out=0, busy_out=0. FSM in IDLE, buffers empty.
- Input latency: a pin change is seen internally SYNC_STAGES cycles later. Edge detection adds 1 cycle.
- rx_valid_out rises SYNC_STAGES+2 cycles after the physical final sample edge.
- miso_out updates SYNC_STAGES+2 cycles after the physical shift edge.
- cpha=0: the first bit is valid on miso_out SYNC_STAGES+2 cycles after ss_n falls. The master must allow at least that setup time before its first sclk edge.
- tx_ready_out falls the cycle after a write and rises the cycle after LOAD consumes the word.

## Configuration
- SPI_SLV_LSB_EN defined: lsb_in is latched at frame start and selects LSB-first in both directions.
- SPI_SLV_LSB_EN undefined: lsb_in is ignored and the core is always MSB first. The port remains present.

## Test plan
- Mode 0, CHAR_LEN=8: tx 0xA5 pre-loaded, master sends 0x3C → rx_dat_out=0x3C with rx_valid_out=1, master receives 0xA5, no underrun.
- Modes 1, 2 and 3, each with tx 0x81 and master sending 0x7E → correct data in both directions for each mode.
- Two back-to-back characters with ss_n held low and no rx_ack_in → second character overwrites rx_dat_out, rx_overrun_out pulses once, rx_valid_out stays 1.
- Empty tx buffer at frame start → tx_underrun_out pulses, master receives 0x00; a word written during LOAD is sent in the next character.
- ss_n raised after 5 bits → no rx_valid_out, FSM returns to IDLE, the next full frame is received correctly. Reset asserted mid-frame → all outputs take their reset values immediately.
- SPI_SLV_LSB_EN defined with lsb_in=1, master LSB-first sending 0x01 → rx_dat_out=0x01. Same stimulus with the macro undefined → rx_dat_out=0x80.

Source files
------------

// File: rtl/spi_slave_core.sv
// rtl/spi_slave_core.sv - SPI slave endpoint, all four CPOL/CPHA modes, oversampled into wb_clk_in.
// Optional LSB-first support is enabled with the SPI_SLV_LSB_EN macro.
module spi_slave_core #(
  parameter int CHAR_LEN    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wb_clk_in,
  input  logic                wb_rst_n_in,
  input  logic                cpol_in,
  input  logic                cpha_in,
  input  logic                lsb_in,
  input  logic                sclk_in,
  input  logic                ss_n_in,
  input  logic                mosi_in,
  output logic                miso_out,
  output logic                miso_oe_out,
  input  logic [CHAR_LEN-1:0] tx_dat_in,
  input  logic                tx_valid_in,
  output logic                tx_ready_out,
  output logic [CHAR_LEN-1:0] rx_dat_out,
  output logic                rx_valid_out,
  input  logic                rx_ack_in,
  output logic                rx_overrun_out,
  output logic                tx_underrun_out,
  output logic                busy_out
);

  localparam int CW = $clog2(CHAR_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_d1_q, ss_d1_q;
  logic                   rise_q, fall_q;
  logic                   sclk_s, ss_s, mosi_s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CHAR_LEN-1:0]    rx_sh_q, rx_sh_d;
  logic [CHAR_LEN-1:0]    tx_sh_q, tx_sh_d;
  logic [CHAR_LEN-1:0]    rx_dat_q, rx_dat_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   ovr_q, ovr_d;
  logic                   und_q, und_d;
  logic [CHAR_LEN-1:0]    buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   cpol_q, cpol_d;
  logic                   cpha_q, cpha_d;
  logic                   lsb_act;

  logic                   ss_fall, lead, trail, sample_ev, shift_ev, tx_wr;
  logic [CHAR_LEN-1:0]    rx_next;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_SLV_LSB_EN
  logic lsb_q, lsb_d;
  assign lsb_act = lsb_q;

  always_ff @(posedge wb_clk_in or negedge wb_rst_n_in) begin
    if (!wb_rst_n_in) lsb_q <= 1'b0;
    else              lsb_q <= lsb_d;
  end

  always_comb begin
    lsb_d = lsb_q;
    if (ss_fall) lsb_d = lsb_in;
  end
`else
  logic unused_lsb;
  assign unused_lsb = lsb_in;
  assign lsb_act    = 1'b0;
`endif

  // Edge pulses are registered raw; lead/trail decoding uses the frame's latched cpol.
  assign ss_fall   = ss_d1_q & ~ss_s;
  assign lead      = cpol_q ? fall_q : rise_q;
  assign trail     = cpol_q ? rise_q : fall_q;
  assign sample_ev = cpha_q ? trail : lead;
  assign shift_ev  = cpha_q ? lead : trail;
  assign tx_wr     = tx_valid_in & ~buf_full_q;
  assign rx_next   = lsb_act ? ((rx_sh_q >> 1) | (CHAR_LEN'(mosi_s) << (CHAR_LEN - 1)))
                             : ((rx_sh_q << 1) | CHAR_LEN'(mosi_s));

  always_ff @(posedge wb_clk_in or negedge wb_rst_n_in) begin
    if (!wb_rst_n_in) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_d1_q   <= 1'b0;
      ss_d1_q     <= 1'b1;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      tx_sh_q     <= '0;
      rx_dat_q    <= '0;
      rx_valid_q  <= 1'b0;
      ovr_q       <= 1'b0;
      und_q       <= 1'b0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_in};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_in};
      sclk_d1_q   <= sclk_s;
      ss_d1_q     <= ss_s;
      rise_q      <= sclk_s & ~sclk_d1_q;
      fall_q      <= ~sclk_s & sclk_d1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      rx_dat_q    <= rx_dat_d;
      rx_valid_q  <= rx_valid_d;
      ovr_q       <= ovr_d;
      und_q       <= und_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    rx_dat_d   = rx_dat_q;
    rx_valid_d = rx_valid_q;
    ovr_d      = 1'b0;
    und_d      = 1'b0;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;

    if (tx_wr) begin
      buf_d      = tx_dat_in;
      buf_full_d = 1'b1;
    end
    if (rx_ack_in) rx_valid_d = 1'b0;
    if (ss_fall) begin
      cpol_d = cpol_in;
      cpha_d = cpha_in;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ss_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cnt_d   = '0;
        rx_sh_d = '0;
        if (buf_full_q) begin
          tx_sh_d    = buf_q;
          buf_full_d = 1'b0;
        end else begin
          tx_sh_d = '0;
          und_d   = 1'b1;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sample_ev) begin
          rx_sh_d = rx_next;
          if (cnt_q == CW'(CHAR_LEN - 1)) begin
            rx_dat_d   = rx_next;
            rx_valid_d = 1'b1;
            ovr_d      = rx_valid_q & ~rx_ack_in;
            cnt_d      = '0;
            state_d    = ST_LOAD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // No shift before the first sample: covers the cpha=1 first leading edge and the
        // cpha=0 final trailing edge that lands after the next character was loaded.
        if (shift_ev && cnt_q != '0)
          tx_sh_d = lsb_act ? (tx_sh_q >> 1) : (tx_sh_q << 1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (ss_s) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end
  end

  assign miso_out        = (state_q == ST_IDLE) ? 1'b0
                         : (lsb_act ? tx_sh_q[0] : tx_sh_q[CHAR_LEN-1]);
  assign miso_oe_out     = ~ss_s;
  assign tx_ready_out    = ~buf_full_q;
  assign rx_dat_out      = rx_dat_q;
  assign rx_valid_out    = rx_valid_q;
  assign rx_overrun_out  = ovr_q;
  assign tx_underrun_out = und_q;
  assign busy_out        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_core.sv
// tb/tb_spi_slave_core.sv - directed self-checking bench for spi_slave_core (CHAR_LEN=8).
module tb_spi_slave_core;

  localparam int H = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [7:0] tx_dat = 8'h00;
  logic       tx_valid = 1'b0, rx_ack = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, rx_ovr, tx_und, busy;
  logic [7:0] rx_dat;

  int         n_checks = 0, n_errors = 0;
  int         und_cnt = 0, ovr_cnt = 0, und0, ovr0;
  bit         tb_lsb = 1'b0;
  logic [7:0] d0, d1;

  spi_slave_core dut (
    .wb_clk_in      (clk),
    .wb_rst_n_in    (rst_n),
    .cpol_in        (cpol),
    .cpha_in        (cpha),
    .lsb_in         (lsb),
    .sclk_in        (sclk),
    .ss_n_in        (ss_n),
    .mosi_in        (mosi),
    .miso_out       (miso),
    .miso_oe_out    (miso_oe),
    .tx_dat_in      (tx_dat),
    .tx_valid_in    (tx_valid),
    .tx_ready_out   (tx_ready),
    .rx_dat_out     (rx_dat),
    .rx_valid_out   (rx_valid),
    .rx_ack_in      (rx_ack),
    .rx_overrun_out (rx_ovr),
    .tx_underrun_out(tx_und),
    .busy_out       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_und) und_cnt = und_cnt + 1;
    if (rx_ovr) ovr_cnt = ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_miso"},     32'(miso),     0);
    check({pfx, "_miso_oe"},  32'(miso_oe),  0);
    check({pfx, "_tx_ready"}, 32'(tx_ready), 1);
    check({pfx, "_rx_dat"},   32'(rx_dat),   0);
    check({pfx, "_rx_valid"}, 32'(rx_valid), 0);
    check({pfx, "_overrun"},  32'(rx_ovr),   0);
    check({pfx, "_underrun"}, 32'(tx_und),   0);
    check({pfx, "_busy"},     32'(busy),     0);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_dat   = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic set_mode(input logic p, input logic h);
    @(negedge clk);
    cpol = p;
    cpha = h;
    sclk = p;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    ss_n = 1'b0;
    #(2 * H);
  endtask

  task automatic frame_end();
    #(2 * H);
    ss_n = 1'b1;
    #(2 * H);
  endtask

  task automatic xfer(input logic [7:0] dout, input int nbits, output logic [7:0] din);
    din = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      int b = tb_lsb ? k : 7 - k;
      if (!cpha) begin
        mosi = dout[b];
        #H;
        sclk = ~cpol;
        din[b] = miso;
        #H;
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = dout[b];
        #H;
        sclk = cpol;
        din[b] = miso;
        #H;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Mode 0 with a preloaded word
    tx_write(8'hA5);
    check("m0_tx_ready_full", 32'(tx_ready), 0);
    und0 = und_cnt;
    frame_start();
    check("m0_underrun", und_cnt - und0, 0);
    check("m0_busy", 32'(busy), 1);
    check("m0_tx_ready_consumed", 32'(tx_ready), 1);
    xfer(8'h3C, 8, d0);
    check("m0_master_rx", 32'(d0), 'hA5);
    frame_end();
    check("m0_rx_dat", 32'(rx_dat), 'h3C);
    check("m0_rx_valid", 32'(rx_valid), 1);
    ack();
    check("m0_rx_valid_acked", 32'(rx_valid), 0);

    for (int m = 1; m < 4; m++) begin
      set_mode(m[1], m[0]);
      tx_write(8'h81);
      frame_start();
      xfer(8'h7E, 8, d0);
      check($sformatf("m%0d_master_rx", m), 32'(d0), 'h81);
      frame_end();
      check($sformatf("m%0d_rx_dat", m), 32'(rx_dat), 'h7E);
      ack();
    end
    set_mode(1'b0, 1'b0);

    // Empty buffer at start, write landing in the LOAD cycle, two chars back-to-back
    und0 = und_cnt;
    ovr0 = ovr_cnt;
    @(negedge clk);
    ss_n = 1'b0;
    repeat (3) @(negedge clk);
    tx_dat   = 8'h5A;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    #(2 * H - 40);
    check("b2b_underrun", und_cnt - und0, 1);
    check("b2b_word_held", 32'(tx_ready), 0);
    xfer(8'h11, 8, d0);
    xfer(8'h22, 8, d1);
    check("b2b_master_rx0", 32'(d0), 'h00);
    check("b2b_master_rx1", 32'(d1), 'h5A);
    #(2 * H);
    check("b2b_rx_dat", 32'(rx_dat), 'h22);
    check("b2b_rx_valid", 32'(rx_valid), 1);
    check("b2b_overrun", ovr_cnt - ovr0, 1);
    ss_n = 1'b1;
    #(2 * H);
    ack();

    // Partial character then a full one
    frame_start();
    xfer(8'hFF, 5, d0);
    ss_n = 1'b1;
    #(2 * H);
    check("part_rx_valid", 32'(rx_valid), 0);
    check("part_busy", 32'(busy), 0);
    check("part_miso_oe", 32'(miso_oe), 0);
    frame_start();
    xfer(8'h96, 8, d0);
    frame_end();
    check("part_next_rx_dat", 32'(rx_dat), 'h96);
    check("part_next_rx_valid", 32'(rx_valid), 1);
    ack();

    // LSB-first master
    @(negedge clk);
    lsb    = 1'b1;
    tb_lsb = 1'b1;
    frame_start();
    xfer(8'h01, 8, d0);
    frame_end();
`ifdef SPI_SLV_LSB_EN
    check("lsb_rx_dat", 32'(rx_dat), 'h01);
`else
    check("lsb_rx_dat", 32'(rx_dat), 'h80);
`endif
    lsb    = 1'b0;
    tb_lsb = 1'b0;

    // Reset in the middle of a frame
    frame_start();
    xfer(8'hC3, 3, d0);
    tx_write(8'h33);
    check("mid_busy", 32'(busy), 1);
    check("mid_tx_ready", 32'(tx_ready), 0);
    check("mid_rx_valid", 32'(rx_valid), 1);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    #9;
    ss_n = 1'b1;
    sclk = cpol;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
